control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 40 ++++
 rtl/control_unit_instr_decode_lut.sv | 52 +++++
 rtl/control_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// Shared opcode, mux-select and FSM-state definitions for the control unit
// and its decode table.
package control_unit_pkg;

  localparam logic [2:0] HLT  = 3'd0;
  localparam logic [2:0] STO  = 3'd1;
  localparam logic [2:0] LD   = 3'd2;
  localparam logic [2:0] LDI  = 3'd3;
  localparam logic [2:0] ADD  = 3'd4;
  localparam logic [2:0] ADDI = 3'd5;
  localparam logic [2:0] SUB  = 3'd6;
  localparam logic [2:0] SUBI = 3'd7;

  localparam logic [1:0] SEL_MEM = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_ALU = 2'd2;

  typedef logic [1:0] stateT;
  localparam stateT RUN       = 2'd0;
  localparam stateT HALT_REQ  = 2'd1;
  localparam stateT HALT_WAIT = 2'd2;
  localparam stateT HALTED    = 2'd3;

  // One decoded instruction; upd* flags say which held selects get rewritten.
  typedef struct packed {
    logic       wrPC;
    logic       wrAcc;
    logic       wrRam;
    logic       rdRam;
    logic       updSelA;
    logic [1:0] selA;
    logic       updSelB;
    logic       selB;
    logic       updOp;
    logic       op;
    logic       isHalt;
    logic       isIllegal;
  } ctrlWordT;

endpackage

// File: rtl/control_unit_instr_decode_lut.sv
// Purely combinational opcode-to-control lookup; any opcode with bits above
// the low three set is flagged illegal and drives nothing else.
module instr_decode_lut
  import control_unit_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opCode,
  output ctrlWordT            ctrl
);

  always_comb begin
    ctrl = '0;
    if (|opCode[OPCODE_W-1:3]) begin
      ctrl.isIllegal = 1'b1;
    end else begin
      case (opCode[2:0])
        HLT: ctrl.isHalt = 1'b1;
        STO: begin
          ctrl.wrPC  = 1'b1;
          ctrl.wrRam = 1'b1;
        end
        LD: begin
          ctrl.wrPC    = 1'b1;
          ctrl.rdRam   = 1'b1;
          ctrl.wrAcc   = 1'b1;
          ctrl.updSelA = 1'b1;
          ctrl.selA    = SEL_MEM;
        end
        LDI: begin
          ctrl.wrPC    = 1'b1;
          ctrl.wrAcc   = 1'b1;
          ctrl.updSelA = 1'b1;
          ctrl.selA    = SEL_IMM;
        end
        default: begin
          // ADD/ADDI/SUB/SUBI: bit0 picks immediate, bit1 clear means add.
          ctrl.wrPC    = 1'b1;
          ctrl.wrAcc   = 1'b1;
          ctrl.rdRam   = ~opCode[0];
          ctrl.updSelA = 1'b1;
          ctrl.selA    = SEL_ALU;
          ctrl.updSelB = 1'b1;
          ctrl.selB    = opCode[0];
          ctrl.updOp   = 1'b1;
          ctrl.op      = ~opCode[1];
        end
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Registered control unit: decodes accepted opcodes one cycle later and runs
// the halt / UART-report / resume state machine.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int OPCODE_W     = 5,
  parameter bit UART_ON_HALT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic                tx_done,
  input  logic                resume,
  output logic                WrPC,
  output logic                WrAcc,
  output logic                WrRam,
  output logic                RdRam,
  output logic [1:0]          SelA,
  output logic                SelB,
  output logic                Op,
  output logic                wr_uart,
  output logic                halted,
  output logic                illegal
);

  if (OPCODE_W < 4) begin : gBadWidth
    $error("control_unit: OPCODE_W must be at least 4");
  end

  stateT    stateReg;
  stateT    stateNext;
  ctrlWordT dec;
  logic     accept;

  instr_decode_lut #(.OPCODE_W(OPCODE_W)) uDecode (
    .opCode (OpCode),
    .ctrl   (dec)
  );

  assign accept = i_valid && (stateReg == RUN);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RUN:       if (accept && dec.isHalt) stateNext = UART_ON_HALT ? HALT_REQ : HALTED;
      HALT_REQ:  stateNext = HALT_WAIT;
      HALT_WAIT: if (tx_done) stateNext = HALTED;
      HALTED:    if (resume) stateNext = RUN;
      default:   stateNext = RUN;
    endcase
  end

  // wr_uart and halted are derived from the next state so they line up with
  // the state register rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= RUN;
      WrPC     <= 1'b0;
      WrAcc    <= 1'b0;
      WrRam    <= 1'b0;
      RdRam    <= 1'b0;
      SelA     <= SEL_MEM;
      SelB     <= 1'b0;
      Op       <= 1'b0;
      wr_uart  <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      WrPC     <= accept && dec.wrPC;
      WrAcc    <= accept && dec.wrAcc;
      WrRam    <= accept && dec.wrRam;
      RdRam    <= accept && dec.rdRam;
      if (accept && dec.updSelA) SelA <= dec.selA;
      if (accept && dec.updSelB) SelB <= dec.selB;
      if (accept && dec.updOp)   Op   <= dec.op;
      wr_uart  <= (stateNext == HALT_REQ);
      halted   <= (stateNext != RUN);
      illegal  <= illegal || (accept && dec.isIllegal);
    end
  end

endmodule
